parameter_tx_framer: RTL

Transmit-side counterpart of the parameter receive RAM path. Reads a block of 32-bit parameter words from one port of a dual-port parameter RAM, frames them into a checksummed byte stream and emits the stream over a valid/ready byte interface toward the serial link driver. The CPU side fills the TX RAM and pulses `start`. The framer reports completion with `done`.

---
 rtl/parameter_tx_framer_if.sv | 22 ++
 rtl/parameter_tx_framer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/parameter_tx_framer_if.sv
// Framer-side bus bundle: RAM read port toward the TX parameter RAM and the
// valid/ready byte stream toward the serial link driver.
interface parameter_tx_framer_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic [31:0]       ram_readdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_address, ram_chipselect, tx_data, tx_valid,
    input  ram_readdata, tx_ready
  );

  modport slave (
    input  ram_address, ram_chipselect, tx_data, tx_valid,
    output ram_readdata, tx_ready
  );
endinterface

// File: rtl/parameter_tx_framer.sv
// Reads a block of 32-bit parameter words from RAM and emits them as a framed,
// checksummed byte stream: SOF, LEN_HI, LEN_LO, payload (LSB first), CSUM.
module parameter_tx_framer #(
  parameter int          ADDR_W   = 11,
  parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  parameter_tx_framer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_LEN_HI, S_LEN_LO, S_FETCH, S_WAIT,
    S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3, S_CSUM
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W:0]   idx_r;
  logic [31:0]       shift_r;
  logic [7:0]        sum_r;
  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              cs_r;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;

  logic              xfer_s;
  logic              more_s;
  logic [7:0]        sum_next_s;
  logic [15:0]       len_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // Transfer detect, running-sum lookahead and remaining-word test.
  always_comb begin
    xfer_s     = 1'b0;
    more_s     = 1'b0;
    sum_next_s = sum_r;
    len_s      = 16'(count_r);
    if (tx_valid_r && bus.tx_ready) begin
      xfer_s     = 1'b1;
      sum_next_s = csum_add(sum_r, tx_data_r);
    end else begin
      xfer_s     = 1'b0;
      sum_next_s = sum_r;
    end
    if (idx_r != {1'b0, count_r}) begin
      more_s = 1'b1;
    end else begin
      more_s = 1'b0;
    end
  end

  // Frame sequencer; every output is driven straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      base_r     <= {ADDR_W{1'b0}};
      count_r    <= {ADDR_W{1'b0}};
      idx_r      <= {(ADDR_W+1){1'b0}};
      shift_r    <= 32'h0000_0000;
      sum_r      <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      cs_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      if ((state_r != S_IDLE) && abort) begin
        state_r    <= S_IDLE;
        tx_valid_r <= 1'b0;
        cs_r       <= 1'b0;
        busy_r     <= 1'b0;
        aborted_r  <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              base_r     <= base_addr;
              count_r    <= word_count;
              idx_r      <= {(ADDR_W+1){1'b0}};
              sum_r      <= 8'h00;
              tx_data_r  <= SOF_BYTE;
              tx_valid_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= S_SOF;
            end
          end
          S_SOF: begin
            if (xfer_s) begin
              tx_data_r <= len_s[15:8];
              state_r   <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (xfer_s) begin
              sum_r     <= sum_next_s;
              tx_data_r <= len_s[7:0];
              state_r   <= S_LEN_LO;
            end
          end
          S_LEN_LO, S_BYTE3: begin
            if (xfer_s) begin
              sum_r <= sum_next_s;
              // idx_r counts words already fetched, so it is also the next offset.
              if (((state_r == S_LEN_LO) && (count_r != {ADDR_W{1'b0}})) ||
                  ((state_r == S_BYTE3) && more_s)) begin
                tx_valid_r <= 1'b0;
                cs_r       <= 1'b1;
                addr_r     <= base_r + idx_r[ADDR_W-1:0];
                state_r    <= S_FETCH;
              end else begin
                tx_data_r <= 8'h00 - sum_next_s;
                state_r   <= S_CSUM;
              end
            end
          end
          S_FETCH: begin
            cs_r    <= 1'b0;
            idx_r   <= idx_r + {{ADDR_W{1'b0}}, 1'b1};
            state_r <= S_WAIT;
          end
          S_WAIT: begin
            shift_r    <= bus.ram_readdata;
            tx_data_r  <= bus.ram_readdata[7:0];
            tx_valid_r <= 1'b1;
            state_r    <= S_BYTE0;
          end
          S_BYTE0, S_BYTE1, S_BYTE2: begin
            if (xfer_s) begin
              sum_r     <= sum_next_s;
              shift_r   <= {8'h00, shift_r[31:8]};
              tx_data_r <= shift_r[15:8];
              state_r   <= state_t'(state_r + 4'd1);
            end
          end
          S_CSUM: begin
            if (xfer_s) begin
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= S_IDLE;
            end
          end
          default: begin
            state_r    <= S_IDLE;
            tx_valid_r <= 1'b0;
            cs_r       <= 1'b0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_data        = tx_data_r;
  assign bus.tx_valid       = tx_valid_r;
  assign bus.ram_chipselect = cs_r;
  assign bus.ram_address    = addr_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign aborted            = aborted_r;

endmodule
